// File: rtl/game_reg_pkg.sv
`default_nettype none
// game_reg_pkg: shared types and constants for the GameIP register-port arbiter.
// Rev 1.0
package game_reg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] GAME_REG_0 = 4'h0;
  localparam logic [3:0] GAME_REG_1 = 4'h4;
  localparam logic [3:0] GAME_REG_2 = 4'h8;
  localparam logic [3:0] GAME_REG_3 = 4'hC;

endpackage
`default_nettype wire

// File: rtl/game_reg_arbiter_rr_arbiter.sv
`default_nettype none
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
// Rev 1.0
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Candidate position ptr+k, folded back into 0..NUM_REQ-1.
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!any && req[cand[IDX_W-1:0]]) begin
        any = 1'b1;
        idx = cand[IDX_W-1:0];
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/game_reg_arbiter.sv
`default_nettype none
// game_reg_arbiter: round-robin sharing of one AXI4-Lite master port among NUM_REQ requesters.
// Rev 1.0
module game_reg_arbiter
  import game_reg_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic [1:0]                     rsp_resp,
  output logic [ADDR_WIDTH-1:0]          M_AXI_AWADDR,
  output logic [2:0]                     M_AXI_AWPROT,
  output logic                           M_AXI_AWVALID,
  input  logic                           M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]          M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]        M_AXI_WSTRB,
  output logic                           M_AXI_WVALID,
  input  logic                           M_AXI_WREADY,
  input  logic [1:0]                     M_AXI_BRESP,
  input  logic                           M_AXI_BVALID,
  output logic                           M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]          M_AXI_ARADDR,
  output logic [2:0]                     M_AXI_ARPROT,
  output logic                           M_AXI_ARVALID,
  input  logic                           M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]          M_AXI_RDATA,
  input  logic [1:0]                     M_AXI_RRESP,
  input  logic                           M_AXI_RVALID,
  output logic                           M_AXI_RREADY
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        ptr, idx_q, gidx;
  logic [NUM_REQ-1:0]      grant;
  logic                    gany;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic [1:0]              resp_q;
  logic                    aw_done, w_done;
  logic                    aw_hs, w_hs;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID  && M_AXI_WREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gany) state_nxt = req_we[gidx] ? WR : RD_ADDR;
      WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
      WR_RESP: if (M_AXI_BVALID) state_nxt = DONE;
      RD_ADDR: if (M_AXI_ARREADY) state_nxt = RD_DATA;
      RD_DATA: if (M_AXI_RVALID) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ptr     <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (gany) begin
          idx_q   <= gidx;
          addr_q  <= req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_q <= req_wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
          wstrb_q <= req_wstrb[gidx*STRB_W +: STRB_W];
          rdata_q <= '0;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        WR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        WR_RESP: if (M_AXI_BVALID) resp_q <= M_AXI_BRESP;
        RD_DATA: if (M_AXI_RVALID) begin
          rdata_q <= M_AXI_RDATA;
          resp_q  <= M_AXI_RRESP;
        end
        DONE: ptr <= (idx_q == IDX_W'(NUM_REQ-1)) ? '0 : idx_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Grant is masked while reset is held so nothing looks accepted during reset.
  assign req_ready     = (state == IDLE && ARESETN) ? grant : '0;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = (state == WR) && !aw_done;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = (state == WR) && !w_done;
  assign M_AXI_BREADY  = (state == WR_RESP);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = (state == RD_ADDR);
  assign M_AXI_RREADY  = (state == RD_DATA);

  always_comb begin
    rsp_valid = '0;
    if (state == DONE) rsp_valid[idx_q] = 1'b1;
  end

  assign rsp_rdata = (state == DONE) ? rdata_q : '0;
  assign rsp_resp  = (state == DONE) ? resp_q  : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_game_reg_arbiter.sv
`default_nettype none
// tb_game_reg_arbiter: directed requests, AXI4-Lite slave model and response scoreboard.
// Rev 1.0
module tb_game_reg_arbiter;
  import game_reg_pkg::*;

  localparam int NUM_REQ = 4;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [NUM_REQ-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [NUM_REQ*4-1:0]  req_addr, req_wstrb;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [31:0]           rsp_rdata;
  logic [1:0]            rsp_resp;
  logic [3:0]  awaddr, araddr, wstrb;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  game_reg_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // Slave: ready one cycle after valid (plus aw_delay), B/R one cycle after handshake.
  int          aw_delay = 0;
  logic        r_hold = 1'b0, slverr_en = 1'b0;
  logic [31:0] regs [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
  int          aw_cnt;
  logic        aw_pend, w_pend;
  logic [3:0]  aw_addr_q, w_strb_q;
  logic [31:0] w_data_q;
  logic        aw_hs, w_hs, ar_hs, aw_got, w_got;
  logic [3:0]  eff_addr, eff_strb;
  logic [31:0] eff_data, merged;

  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign ar_hs    = arvalid && arready;
  assign aw_got   = aw_pend || aw_hs;
  assign w_got    = w_pend || w_hs;
  assign eff_addr = aw_hs ? awaddr : aw_addr_q;
  assign eff_data = w_hs ? wdata : w_data_q;
  assign eff_strb = w_hs ? wstrb : w_strb_q;
  always_comb begin
    merged = regs[eff_addr[3:2]];
    for (int b = 0; b < 4; b++) if (eff_strb[b]) merged[b*8 +: 8] = eff_data[b*8 +: 8];
  end

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      arready <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
      aw_cnt <= 0; aw_pend <= 1'b0; w_pend <= 1'b0;
      aw_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0;
    end else begin
      awready <= awvalid && !awready && !aw_pend && (aw_cnt >= aw_delay);
      aw_cnt  <= (awvalid && !aw_hs) ? aw_cnt + 1 : 0;
      wready  <= wvalid && !wready && !w_pend;
      if (aw_hs) begin aw_pend <= 1'b1; aw_addr_q <= awaddr; end
      if (w_hs) begin w_pend <= 1'b1; w_data_q <= wdata; w_strb_q <= wstrb; end
      if (aw_got && w_got && !bvalid) begin
        regs[eff_addr[3:2]] <= merged;
        bvalid <= 1'b1; bresp <= RESP_OKAY;
        aw_pend <= 1'b0; w_pend <= 1'b0;
      end else if (bvalid && bready) bvalid <= 1'b0;
      arready <= arvalid && !arready;
      if (ar_hs) begin
        rdata <= regs[araddr[3:2]];
        rresp <= (slverr_en && araddr == 4'h8) ? RESP_SLVERR : RESP_OKAY;
        if (!r_hold) rvalid <= 1'b1;
      end else if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  typedef struct {int idx; logic we; logic [3:0] addr; logic [31:0] wdata; logic [3:0] strb;} req_t;
  typedef struct {int idx; logic [31:0] rdata; logic [1:0] resp; int lat;} exp_t;
  req_t pend[$];
  exp_t sb[$];
  int checks = 0, errors = 0;
  int w_first_cnt = 0, b_cnt = 0;

  task automatic add_req(input int i, input logic we, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_t r;
    r.idx = i; r.we = we; r.addr = a; r.wdata = d; r.strb = s;
    pend.push_back(r);
  endtask

  task automatic expect_rsp(input int i, input logic [31:0] d, input logic [1:0] r, input int lat);
    exp_t e;
    e.idx = i; e.rdata = d; e.resp = r; e.lat = lat;
    sb.push_back(e);
  endtask

  // Requesters: hold a request until accepted, then scramble the bus and load the next one.
  initial begin : driver
    logic [NUM_REQ-1:0] acc;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    forever begin
      @(negedge ACLK); acc = req_ready;
      @(posedge ACLK); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) begin
          req_valid[i] = 1'b0; req_we[i] = ~req_we[i];
          req_addr[i*4 +: 4] = 4'hF; req_wdata[i*32 +: 32] = 32'hDEAD_BEEF;
        end
        if (!req_valid[i]) begin
          for (int j = 0; j < pend.size(); j++) begin
            if (pend[j].idx == i) begin
              req_valid[i] = 1'b1; req_we[i] = pend[j].we;
              req_addr[i*4 +: 4] = pend[j].addr; req_wdata[i*32 +: 32] = pend[j].wdata;
              req_wstrb[i*4 +: 4] = pend[j].strb;
              pend.delete(j);
              break;
            end
          end
        end
      end
    end
  end

  initial begin : monitor
    int cyc, gcyc, lat;
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [3:0] p_awa, p_ara;
    logic [31:0] p_wd;
    logic [NUM_REQ-1:0] oh;
    exp_t e;
    cyc = 0; gcyc = 0;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    p_awa = '0; p_ara = '0; p_wd = '0;
    forever begin
      @(negedge ACLK); cyc++;
      if (req_ready != '0) gcyc = cyc;
      if (awvalid && !wvalid) w_first_cnt++;
      if (bvalid && bready) b_cnt++;
      if (ARESETN && ((p_awv && !p_awr) || (p_wv && !p_wr) || (p_arv && !p_arr))) begin
        checks++;
        if ((p_awv && !p_awr && !(awvalid && awaddr == p_awa)) ||
            (p_wv && !p_wr && !(wvalid && wdata == p_wd)) ||
            (p_arv && !p_arr && !(arvalid && araddr == p_ara))) begin
          errors++;
          $display("FAIL valid_hold: got aw=%b w=%b ar=%b, required held with stable payload",
                   awvalid, wvalid, arvalid);
        end
      end
      if (rsp_valid != '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got rsp_valid=%b, required none", rsp_valid);
        end else begin
          e = sb.pop_front();
          lat = cyc - gcyc;
          oh = '0; oh[e.idx] = 1'b1;
          if (rsp_valid != oh || rsp_rdata != e.rdata || rsp_resp != e.resp || lat != e.lat) begin
            errors++;
            $display("FAIL rsp: got valid=%b rdata=%h resp=%b lat=%0d, required valid=%b rdata=%h resp=%b lat=%0d",
                     rsp_valid, rsp_rdata, rsp_resp, lat, oh, e.rdata, e.resp, e.lat);
          end
        end
      end
      p_awv = awvalid; p_awr = awready; p_awa = awaddr;
      p_wv = wvalid; p_wr = wready; p_wd = wdata;
      p_arv = arvalid; p_arr = arready; p_ara = araddr;
    end
  end

  task automatic wait_idle(input string name);
    for (int c = 0; c < 300; c++) begin
      @(negedge ACLK);
      if (sb.size() == 0 && pend.size() == 0 && req_valid == '0) begin
        repeat (2) @(negedge ACLK);
        return;
      end
    end
    checks++; errors++;
    $display("FAIL timeout_%s: got %0d responses outstanding, required 0", name, sb.size());
  endtask

  task automatic check_outputs_zero(input string name);
    logic any_out;
    any_out = |{req_ready, rsp_valid, rsp_rdata, rsp_resp, awaddr, awprot, awvalid, wdata, wstrb,
                wvalid, bready, araddr, arprot, arvalid, rready};
    checks++;
    if (any_out) begin
      errors++;
      $display("FAIL %s: got some output nonzero (req_ready=%b rsp_valid=%b rready=%b), required all 0",
               name, req_ready, rsp_valid, rready);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int wf0, b0;
    repeat (3) @(posedge ACLK);
    #1 check_outputs_zero("reset_state");
    @(negedge ACLK) ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);

    // All four requesters at once from pointer 0, then readback.
    for (int i = 0; i < 4; i++) begin
      add_req(i, 1'b1, 4'(4*i), 32'(i+1), 4'hF);
      expect_rsp(i, 32'h0, RESP_OKAY, 4);
    end
    wait_idle("wr_all");
    for (int i = 0; i < 4; i++) begin
      add_req(i, 1'b0, 4'(4*i), 32'h0, 4'h0);
      expect_rsp(i, 32'(i+1), RESP_OKAY, 4);
    end
    wait_idle("rd_all");

    // Single write then read by requester 0.
    add_req(0, 1'b1, GAME_REG_1, 32'h0000_0001, 4'hF); expect_rsp(0, 32'h0, RESP_OKAY, 4);
    add_req(0, 1'b0, GAME_REG_1, 32'h0, 4'h0);         expect_rsp(0, 32'h1, RESP_OKAY, 4);
    wait_idle("wr_rd0");

    // Requesters 1 and 2 always pending: grants must alternate.
    for (int k = 0; k < 3; k++) begin
      add_req(1, 1'b0, GAME_REG_1, 32'h0, 4'h0);
      add_req(2, 1'b0, GAME_REG_3, 32'h0, 4'h0);
      expect_rsp(1, 32'h1, RESP_OKAY, 4);
      expect_rsp(2, 32'h4, RESP_OKAY, 4);
    end
    wait_idle("alternate");

    // AWREADY delayed three cycles, partial strobes.
    wf0 = w_first_cnt; b0 = b_cnt; aw_delay = 3;
    add_req(3, 1'b1, GAME_REG_2, 32'hA5A5_5A5A, 4'h3); expect_rsp(3, 32'h0, RESP_OKAY, 7);
    wait_idle("aw_delay");
    aw_delay = 0;
    checks++;
    if (w_first_cnt == wf0) begin
      errors++;
      $display("FAIL w_first: got WVALID never dropped before AWVALID, required it to");
    end
    checks++;
    if (b_cnt - b0 != 1) begin
      errors++;
      $display("FAIL b_count: got %0d B handshakes, required 1", b_cnt - b0);
    end

    slverr_en = 1'b1;
    add_req(3, 1'b0, GAME_REG_2, 32'h0, 4'h0); expect_rsp(3, 32'h0000_5A5A, RESP_SLVERR, 4);
    wait_idle("slverr");
    slverr_en = 1'b0;

    // Leave pointer at 2, then abort a read in RD_DATA with reset.
    add_req(1, 1'b0, GAME_REG_1, 32'h0, 4'h0); expect_rsp(1, 32'h1, RESP_OKAY, 4);
    wait_idle("pre_reset");
    r_hold = 1'b1;
    add_req(1, 1'b0, GAME_REG_0, 32'h0, 4'h0);
    for (int c = 0; c < 20 && !rready; c++) @(negedge ACLK);
    checks++;
    if (!rready) begin
      errors++;
      $display("FAIL reach_rd_data: got RREADY=0, required 1");
    end
    @(negedge ACLK) ARESETN = 1'b0;
    #1 check_outputs_zero("reset_abort");
    r_hold = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    add_req(3, 1'b0, GAME_REG_3, 32'h0, 4'h0);
    add_req(0, 1'b0, GAME_REG_0, 32'h0, 4'h0);
    expect_rsp(0, 32'h1, RESP_OKAY, 4);
    expect_rsp(3, 32'h4, RESP_OKAY, 4);
    wait_idle("post_reset");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d expected responses unseen, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
